// File: rtl/cfg_frame_loader.sv
// Serial config frame loader: deserialises MSB-first frames plus an even-parity bit and strobes each good frame into the addressed bank.
// Latency: frame_we is asserted the cycle after the parity bit is accepted, and it is high for exactly one cycle.
// Backpressure: cfg_ready is high only while shifting. A cfg_valid gap stalls the frame indefinitely; there is no timeout.
//
// Ports: clk/R (async active-low reset), start (begin/restart a load),
//        cfg_bit/cfg_valid/cfg_ready (serial input handshake),
//        frame_data/frame_addr/frame_we (register bank write port),
//        busy/done/error (sequence status; done and error are sticky).
module cfg_frame_loader #(
    parameter int FRAME_WIDTH = 8,
    parameter int NUM_FRAMES  = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   start,
    input  logic                   cfg_bit,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [FRAME_WIDTH-1:0] frame_data,
    output logic [ADDR_WIDTH-1:0]  frame_addr,
    output logic                   frame_we,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int CW = $clog2(FRAME_WIDTH + 1);
    // The bit counter reaches FRAME_WIDTH on the parity-bit transfer.
    localparam logic [CW-1:0]         LAST_BIT  = CW'(FRAME_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic [FRAME_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   busy_q, busy_d;
    logic                   we_q, we_d;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        addr_d  = addr_q;
        done_d  = done_q;
        err_d   = err_q;

        if (start) begin
            // start wins over everything. A bit offered in the same cycle is dropped.
            // frame_data keeps the last good frame.
            state_d = ST_SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
            addr_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cfg_valid) begin
                        sr_d = {sr_q[FRAME_WIDTH-2:0], cfg_bit};
                        if (cnt_q == LAST_BIT) begin
                            // Parity bit: sr_q still holds exactly the data bits.
                            cnt_d = '0;
                            par_d = 1'b0;
                            if (par_q ^ cfg_bit) begin
                                err_d   = 1'b1;
                                state_d = ST_ERR;
                            end else begin
                                data_d  = sr_q;
                                state_d = ST_WRITE;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                            par_d = par_q ^ cfg_bit;
                        end
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = ST_SHIFT;
                    end
                end
                default: ;  // IDLE, DONE and ERR wait for start.
            endcase
        end

        // Outputs are decoded from the next state so that they stay registered.
        cfg_ready_d = (state_d == ST_SHIFT);
        busy_d      = (state_d == ST_SHIFT) || (state_d == ST_WRITE);
        we_d        = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign frame_data = data_q;
    assign frame_addr = addr_q;
    assign frame_we   = we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader with the default parameters (8-bit frames, 4 frames, 2-bit address).
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
// Each frame_we pulse is tallied on the falling edge.
module tb_cfg_frame_loader;

    logic       clk;
    logic       R;
    logic       start;
    logic       cfg_bit;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] frame_data;
    logic [1:0] frame_addr;
    logic       frame_we;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int we_count = 0;
    int cyc_mark;

    cfg_frame_loader #(
        .FRAME_WIDTH(8),
        .NUM_FRAMES (4),
        .ADDR_WIDTH (2)
    ) dut (
        .clk       (clk),
        .R         (R),
        .start     (start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .frame_data(frame_data),
        .frame_addr(frame_addr),
        .frame_we  (frame_we),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_we) we_count = we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " cfg_ready"},  cfg_ready,  0);
        check({tag, " frame_data"}, frame_data, 0);
        check({tag, " frame_addr"}, frame_addr, 0);
        check({tag, " frame_we"},   frame_we,   0);
        check({tag, " busy"},       busy,       0);
        check({tag, " done"},       done,       0);
        check({tag, " error"},      error,      0);
    endtask

    // Eight data bits, MSB first, then the parity bit, with cfg_valid held high.
    // Returns at the sample point of the cycle following the parity transfer.
    task automatic send_frame(input logic [7:0] d, input logic p);
        for (int i = 7; i >= 0; i--) begin
            cfg_bit = d[i]; cfg_valid = 1'b1; tick();
        end
        cfg_bit = p; cfg_valid = 1'b1; tick();
    endtask

    // Same frame, but cfg_valid goes 1,0,1,0,... The idle cycles carry inverted garbage on cfg_bit.
    task automatic send_frame_gaps(input logic [7:0] d, input logic p);
        for (int i = 7; i >= 0; i--) begin
            cfg_bit = d[i];  cfg_valid = 1'b1; tick();
            cfg_bit = ~d[i]; cfg_valid = 1'b0; tick();
        end
        cfg_bit = p; cfg_valid = 1'b1; tick();
    endtask

    task automatic check_write(input string tag, input logic [1:0] a, input logic [7:0] d);
        check({tag, " frame_we"},   frame_we,   1);
        check({tag, " frame_addr"}, frame_addr, a);
        check({tag, " frame_data"}, frame_data, d);
        check({tag, " busy"},       busy,       1);
        check({tag, " cfg_ready"},  cfg_ready,  0);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        R = 1'b0; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;

        // Reset held low for 3 cycles, then released with no start.
        repeat (3) tick();
        check_quiet("in_reset");
        R = 1'b1;
        tick(); tick();
        check_quiet("idle");

        // Good load: A5/0, 3C/0, FF/0, 01/1.
        pulse_start();
        cyc_mark = cyc;
        check("start busy", busy, 1);
        check("start cfg_ready", cfg_ready, 1);
        send_frame(8'hA5, 1'b0); check_write("load0", 2'd0, 8'hA5); tick();
        check("load0 we one cycle", frame_we, 0);
        check("load0 ready again", cfg_ready, 1);
        send_frame(8'h3C, 1'b0); check_write("load1", 2'd1, 8'h3C); tick();
        send_frame(8'hFF, 1'b0); check_write("load2", 2'd2, 8'hFF); tick();
        send_frame(8'h01, 1'b1); check_write("load3", 2'd3, 8'h01); tick();
        check("load done", done, 1);
        check("load busy", busy, 0);
        check("load cfg_ready", cfg_ready, 0);
        check("load frame_we", frame_we, 0);
        check("load cycles", cyc - cyc_mark, 4 * 9 + 4);
        check("load we_count", we_count, 4);
        tick(); tick();
        check("done hold data", frame_data, 8'h01);
        check("done hold addr", frame_addr, 3);

        // Parity error on frame 1.
        pulse_start();
        check("restart clears done", done, 0);
        check("restart addr", frame_addr, 0);
        send_frame(8'hA5, 1'b0); check_write("perr0", 2'd0, 8'hA5); tick();
        send_frame(8'h3C, 1'b1);
        check("perr error", error, 1);
        check("perr frame_we", frame_we, 0);
        check("perr frame_data", frame_data, 8'hA5);
        check("perr cfg_ready", cfg_ready, 0);
        check("perr busy", busy, 0);
        check("perr done", done, 0);
        tick(); tick();
        check("perr sticky", error, 1);
        check("perr we_count", we_count, 5);

        // Gaps in cfg_valid: only the valid cycles shift.
        pulse_start();
        check("gap start clears error", error, 0);
        send_frame_gaps(8'h5A, 1'b0); check_write("gap0", 2'd0, 8'h5A); tick();
        check("gap0 leave write", frame_we, 0);

        // Restart after 5 bits of frame 2. The start-cycle bit is discarded.
        send_frame(8'h3C, 1'b0); check_write("rst1", 2'd1, 8'h3C); tick();
        for (int i = 0; i < 5; i++) begin
            cfg_bit = 1'b1; cfg_valid = 1'b1; tick();
        end
        start = 1'b1; cfg_bit = 1'b1; cfg_valid = 1'b1; tick(); start = 1'b0;
        check("restart frame_addr", frame_addr, 0);
        check("restart busy", busy, 1);
        check("restart cfg_ready", cfg_ready, 1);
        check("restart data held", frame_data, 8'h3C);
        send_frame(8'h81, 1'b0); check_write("restart0", 2'd0, 8'h81); tick();
        check("restart we_count", we_count, 8);
        check("restart next addr", frame_addr, 1);

        // Async reset dropped while frame_we is high.
        send_frame(8'hC3, 1'b0); check_write("arst", 2'd1, 8'hC3);
        #2 R = 1'b0;
        #1;
        check("arst frame_we", frame_we, 0);
        check("arst frame_data", frame_data, 0);
        check("arst busy", busy, 0);
        check("arst frame_addr", frame_addr, 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        R = 1'b1;
        tick(); tick();
        check_quiet("after arst");
        check("final we_count", we_count, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Serial configuration frame loader that sits directly upstream of the enable/set register banks (dffes cells) in the K4_N8 custom techlib flow.
- Deserialises a bit stream into FRAME_WIDTH-bit frames, checks even parity per frame, and drives frame_data plus a one-cycle frame_we strobe.
- frame_data feeds the D pins and frame_we, decoded by frame_addr, feeds the E pins of the addressed register bank.
- Sequences NUM_FRAMES frames per load, then reports done or error.

Parameters:
- FRAME_WIDTH, 8, data bits per frame (>=2).
- NUM_FRAMES, 4, frames per load sequence (>=1).
- ADDR_WIDTH, 2, width of frame_addr; must satisfy 2**ADDR_WIDTH >= NUM_FRAMES.

Ports:
- clk  in  1  rising-edge clock.
- R  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a load sequence.
- cfg_bit  in  1  serial data, MSB of each frame first, then 1 parity bit.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_ready  out  1  loader accepts cfg_bit this cycle.
- frame_data  out  FRAME_WIDTH  last completed frame, held stable.
- frame_addr  out  ADDR_WIDTH  index of frame_data.
- frame_we  out  1  one-cycle write strobe for the addressed bank.
- busy  out  1  load sequence in progress.
- done  out  1  sticky; all NUM_FRAMES frames written.
- error  out  1  sticky; parity failure.

Behaviour:
- Reset (R low, async): state=IDLE. All outputs are 0: cfg_ready, frame_data, frame_addr, frame_we, busy, done, error. Internal shift register, bit counter and parity accumulator are cleared.
- States: IDLE, SHIFT, WRITE, DONE, ERR.
- A bit transfers only when cfg_valid && cfg_ready.
- cfg_ready=1 only in SHIFT. busy=1 in SHIFT and WRITE.
- IDLE -> SHIFT on start: clears done, error, frame_addr, bit counter and parity.
- SHIFT: each transfer shifts cfg_bit into the LSB of the shift register, XORs it into the parity accumulator and increments the bit counter (width $clog2(FRAME_WIDTH+1)).
  - The first FRAME_WIDTH transfers are data. Transfer FRAME_WIDTH+1 is the parity bit.
  - Even parity: XOR of the data bits and the parity bit must be 0.
- On the parity-bit transfer (cycle t):
  - Good parity: frame_data <= shift register; next state WRITE.
  - Bad parity: error <= 1; frame_data is unchanged; next state ERR.
  - Both cases clear the bit counter and the parity accumulator.
- WRITE (cycle t+1): frame_we=1 for exactly one cycle; frame_data and frame_addr are stable for the whole cycle.
  - If frame_addr == NUM_FRAMES-1: next state DONE, done <= 1.
  - Otherwise frame_addr <= frame_addr+1 and next state SHIFT.
- frame_data and frame_addr hold their values until the next good frame or next start. frame_addr never wraps within a sequence.
- DONE and ERR: hold all outputs; cfg_ready=0. start -> SHIFT with the same clearing as from IDLE.
- start while in SHIFT or WRITE: aborts the sequence.
  - Next state SHIFT; frame_addr, counter and parity are cleared.
  - An in-flight frame_we still completes its cycle if already in WRITE.
  - A cfg transfer in the same cycle as start is discarded.
- cfg_valid low in SHIFT: no state change and no timeout.
- frame_we is never asserted outside WRITE and never for a frame with bad parity.
- Reset asserted mid-frame: immediate return to the reset state. Any partial frame is lost and no frame_we is issued.

Test Plan:
- Reset then idle: R low for 3 cycles, then high with no start -> all outputs 0, cfg_ready=0, state stays IDLE.
- Good load, defaults: start, then 4 frames with data 0xA5/0x3C/0xFF/0x01 and parity bits 0/0/0/1, cfg_valid held high.
  - frame_we pulses 4 times, each 1 cycle after its parity bit, with (addr,data) = (0,0xA5), (1,0x3C), (2,0xFF), (3,0x01).
  - Then done=1 and busy=0; the total is 4*9 transfer cycles plus 4 WRITE cycles.
- Parity error: frame 1 = 0x3C with parity bit 1 -> no frame_we for addr 1; error=1, state ERR, frame_data stays 0xA5, cfg_ready=0.
- Backpressure/gaps: cfg_valid toggled 1,0,1,0 during a frame -> only valid cycles shift; result is identical to the gapless case.
- Restart: start asserted after 5 bits of frame 2 -> frame_addr=0 and the counter is cleared; the next full frame writes to addr 0; no stray frame_we.
- Async reset mid-WRITE: R dropped during a frame_we cycle -> frame_we, frame_data and busy are 0 immediately, before the next clk edge.
